// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: EMPTY/NORMAL/FULL state machine, occupancy count, sticky errors.
// Define FIFO_CTRL_ALMOST_EN to add registered almost-full/almost-empty flags.
module fifo_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iPush,
  input  logic              iPop,
  output logic              oWr,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic              oRd,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oFull,
  output logic              oEmpty,
  output logic [ADDR_W:0]   oCount,
  output logic              oOvf,
  output logic              oUdf
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic              oAlmostFull,
  output logic              oAlmostEmpty
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_NORMAL = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic [ADDR_W:0] w_count_next;
  logic            r_ovf;
  logic            r_udf;
  logic            w_push;
  logic            w_pop;

  assign oFull  = (r_state == ST_FULL);
  assign oEmpty = (r_state == ST_EMPTY);

  // When full, a simultaneous pop frees the slot the push writes into.
  assign w_push = iPush & (~oFull | iPop);
  assign w_pop  = iPop & ~oEmpty;

  assign oWr     = w_push;
  assign oRd     = w_pop;
  assign oWrAddr = r_wr_ptr[ADDR_W-1:0];
  assign oRdAddr = r_rd_ptr[ADDR_W-1:0];
  assign oCount  = r_count;
  assign oOvf    = r_ovf;
  assign oUdf    = r_udf;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) w_state_next = ST_NORMAL;
      end
      ST_NORMAL: begin
        if (w_push && !w_pop && r_count == CNT_LAST)
          w_state_next = ST_FULL;
        else if (w_pop && !w_push && r_count == CNT_ONE)
          w_state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_pop && !w_push) w_state_next = ST_NORMAL;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state  <= ST_EMPTY;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + CNT_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + CNT_ONE;
      if (iPush && !iPop && oFull) r_ovf <= 1'b1;
      if (iPop && oEmpty)          r_udf <= 1'b1;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT = (ADDR_W+1)'(AE_LEVEL);

  logic r_almost_full;
  logic r_almost_empty;

  // Computed from the next count so the flags move on the same edge as oCount.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_next >= AF_CNT);
      r_almost_empty <= (w_count_next <= AE_CNT);
    end
  end

  assign oAlmostFull  = r_almost_full;
  assign oAlmostEmpty = r_almost_empty;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed boundary sequences plus random push/pop
// against an occupancy/address model.
module tb_fifo_ctrl;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst_n;
  logic              push;
  logic              pop;
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd;
  logic [ADDR_W-1:0] rd_addr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;
`ifdef FIFO_CTRL_ALMOST_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model
  int m_count;
  int m_wr;
  int m_rd;
  bit m_ovf;
  bit m_udf;

  fifo_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
    .iClk    (clk),
    .iRst_n  (rst_n),
    .iPush   (push),
    .iPop    (pop),
    .oWr     (wr),
    .oWrAddr (wr_addr),
    .oRd     (rd),
    .oRdAddr (rd_addr),
    .oFull   (full),
    .oEmpty  (empty),
    .oCount  (count),
    .oOvf    (ovf),
    .oUdf    (udf)
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    .oAlmostFull  (almost_full),
    .oAlmostEmpty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check_eq("count", int'(count), m_count);
    check_eq("empty", int'(empty), int'(m_count == 0));
    check_eq("full", int'(full), int'(m_count == DEPTH));
    check_eq("wr_addr", int'(wr_addr), m_wr);
    check_eq("rd_addr", int'(rd_addr), m_rd);
    check_eq("ovf", int'(ovf), int'(m_ovf));
    check_eq("udf", int'(udf), int'(m_udf));
`ifdef FIFO_CTRL_ALMOST_EN
    check_eq("almost_full", int'(almost_full), int'(m_count >= 28));
    check_eq("almost_empty", int'(almost_empty), int'(m_count <= 4));
`endif
  endtask

  // One cycle: drive inputs, check combinational and registered outputs, then advance model across the edge.
  task automatic step(input bit p, input bit q);
    bit acc_push;
    bit acc_pop;
    @(negedge clk);
    push = p;
    pop  = q;
    #1;
    acc_push = p && (m_count < DEPTH || q);
    acc_pop  = q && (m_count > 0);
    check_state();
    check_eq("wr", int'(wr), int'(acc_push));
    check_eq("rd", int'(rd), int'(acc_pop));
    if (p && !q && m_count == DEPTH) m_ovf = 1'b1;
    if (q && m_count == 0)           m_udf = 1'b1;
    if (acc_push) m_wr = (m_wr + 1) % DEPTH;
    if (acc_pop)  m_rd = (m_rd + 1) % DEPTH;
    m_count = m_count + int'(acc_push) - int'(acc_pop);
    $display("cycle push=%0b pop=%0b -> model count=%0d wr=%0d rd=%0d", p, q, m_count, m_wr, m_rd);
  endtask

  // Reset for one edge with a push pending, which must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push  = 1'b1;
    pop   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push  = 1'b0;
    m_count = 0;
    m_wr = 0;
    m_rd = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check_state();
    check_eq("rst_rd", int'(rd), 0);
    $display("reset applied");
  endtask

  initial begin
    rst_n = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    do_reset();

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);                                   // overflow attempt
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);                                   // underflow attempt
    step(1'b1, 1'b1);                                   // both while empty
    step(1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);      // streaming while full
    for (int i = 0; i < 28; i++) step(1'b0, 1'b1);      // down to 4
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      if ($urandom_range(0, 99) == 0) do_reset();
      else if (bias == 0) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      else if (bias == 1) step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
